uart_tx_port: RTL and testbench
===============================

Name: uart_tx_port

Overview:
- Memory-mapped serial output peripheral on the processor data bus, beside the RAM and the flip-flop register behind the chipset decode.
- Consumes processor stores (WriteData/DataAdr/MemWrite) to a TX address, buffers bytes in a small FIFO and shifts them out as 8N1 asynchronous serial, LSB first.
- Exposes a status word that the top-level read mux returns as ReadData.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200).
- BASE, 32'h4700, word address of the TXDATA register; STATUS is at BASE+4.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low; 0 resets all state immediately.
- adr  in  32  processor data address (DataAdr).
- we  in  1  processor store strobe (MemWrite).
- wdata  in  32  processor store data (WriteData).
- rdata  out  32  status word, combinational from adr; 0 when adr is neither BASE nor BASE+4.
- sel  out  1  high when adr is BASE or BASE+4; used by the read mux.
- tx  out  1  serial line; idle high.
- irq_empty  out  1  registered; high while the FIFO is empty and the serializer is idle.

Behaviour:
- Reset values: tx=1, irq_empty=1, FIFO empty (count=0, pointers 0), FSM IDLE, baud counter 0, overflow flag 0.
- Push: on a clock edge with we=1 and adr==BASE, wdata[7:0] is written at the write pointer; wdata[31:8] is ignored.
- Overflow: a push while full drops the byte and sets the sticky overflow flag. The FIFO is unchanged.
- Clearing overflow: a write to BASE+4 with wdata[3]=1 clears the flag. Other STATUS bits are read-only.
- STATUS layout:
  - bit0 full
  - bit1 empty
  - bit2 busy (FSM not IDLE)
  - bit3 overflow
  - bits[7:4] count (saturates at 15 if DEPTH>15)
  - bits[31:8] 0
- FIFO: pointers of width log2(DEPTH), wrapping modulo DEPTH. Count has one extra bit.
- Simultaneous push and pop in one cycle: both take effect and count is unchanged. This holds even when full (the pop frees the slot in the same edge), so the push is accepted and overflow is not set.
- FSM states and transitions:
  - IDLE: tx=1. If FIFO not empty: pop the head into an 8-bit shift register, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE. A queued byte starts in the next cycle.
- tx is driven from a register, so the line cannot glitch.
- Latency: a push into an empty FIFO with the FSM idle makes tx fall 2 clocks after the push edge (edge 1 stores, edge 2 pops and enters START).
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames add 1 IDLE cycle between them.
- Baud counter counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit.
- Reset asserted mid-frame aborts the frame: tx goes to 1 asynchronously and FIFO contents are discarded.
- A write to any address other than BASE or BASE+4 has no effect, even if we=1.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t
  - localparams for the TXDATA/STATUS offsets (0, 4)
  - STATUS bit indices
- Sub-module fifo_sync (parameters WIDTH, DEPTH; ports push/pop/din/dout/full/empty/count) holds the storage and pointers.
- uart_tx_port contains the address decode, the overflow flag, the baud counter and the FSM.

Test Plan:
- Reset: with CLKS_PER_BIT=4, hold reset=0 for 3 clocks then release -> tx=1, irq_empty=1, read at 32'h4704 returns 32'h00000002.
- Single byte: store 32'hFFFFFF55 to 32'h4700 -> tx falls 2 clocks later. The bit sequence, each bit 4 clocks, is 0,1,0,1,0,1,0,1,0,1 (start, 55h LSB-first, stop). The frame is 40 cycles, then irq_empty=1.
- Fill and overflow (DEPTH=8): 9 stores of 8'h01..8'h09 on consecutive cycles -> the first byte leaves the FIFO immediately, so the ninth is accepted and overflow=0. A tenth store of 8'h0A while count=8 sets STATUS bit3=1 and full=1. The line then emits 01..09 in order with 1 idle cycle between frames.
- Overflow clear: store 32'h8 to 32'h4704 -> bit3 reads 0 next cycle, and the FIFO count is unchanged.
- Simultaneous push and pop when full: time a store to the cycle the FSM pops -> count stays 8 and overflow stays 0.
- Mid-frame reset: assert reset=0 during DATA bit 3 of byte 8'hA5 -> tx=1 with no clock edge needed. After release the FIFO is empty and no further frames appear.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and register map for the serial TX port
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   localparam logic [31:0] TXDATA_OFS = 32'd0;
   localparam logic [31:0] STATUS_OFS = 32'd4;

   localparam int ST_FULL    = 0;
   localparam int ST_EMPTY   = 1;
   localparam int ST_BUSY    = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 4;
   localparam int ST_CNT_MSB = 7;

endpackage

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock FIFO; a pop frees a slot for a push on the same edge
module fifo_sync #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   localparam int DEPTH_I = DEPTH;
   localparam logic [AW:0] FULL_CNT = DEPTH_I[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_port.sv
// rtl/uart_tx_port.sv - memory-mapped 8N1 serial transmitter with byte FIFO and status word
module uart_tx_port #(
   parameter int          DEPTH        = 8,
   parameter int          CLKS_PER_BIT = 434,
   parameter logic [31:0] BASE         = 32'h4700
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] adr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        sel,
   output logic        tx,
   output logic        irq_empty
);
   import uart_pkg::*;

   localparam int AW     = $clog2(DEPTH);
   localparam int BW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int LAST_I = CLKS_PER_BIT - 1;
   localparam logic [BW-1:0] BAUD_LAST = LAST_I[BW-1:0];

   tx_state_t     state;
   logic [BW-1:0] baud;
   logic [7:0]    shift;
   logic [2:0]    idx;
   logic          ovf;
   logic          hit_data;
   logic          hit_stat;
   logic          push;
   logic          pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [AW:0]   fifo_cnt;
   logic [7:0]    fifo_dout;
   logic [31:0]   cnt_wide;
   logic [31:0]   status;
   logic          unused_wdata;

   assign hit_data     = (adr == BASE + TXDATA_OFS);
   assign hit_stat     = (adr == BASE + STATUS_OFS);
   assign sel          = hit_data || hit_stat;
   assign push         = we && hit_data;
   assign pop          = (state == IDLE) && !fifo_empty;
   assign unused_wdata = ^wdata[31:8];

   fifo_sync #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (wdata[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_cnt)
   );

   assign cnt_wide = 32'(fifo_cnt);

   always_comb begin
      status = '0;
      status[ST_FULL]  = fifo_full;
      status[ST_EMPTY] = fifo_empty;
      status[ST_BUSY]  = (state != IDLE);
      status[ST_OVF]   = ovf;
      status[ST_CNT_MSB:ST_CNT_LSB] = (cnt_wide > 32'd15) ? 4'hF : cnt_wide[3:0];
      rdata = sel ? status : '0;
   end

   // A push into a full FIFO is only lost if the serializer is not popping on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf <= 1'b0;
      end else if (we && hit_stat && wdata[ST_OVF]) begin
         ovf <= 1'b0;
      end else if (push && fifo_full && !pop) begin
         ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         baud      <= '0;
         shift     <= '0;
         idx       <= '0;
         tx        <= 1'b1;
         irq_empty <= 1'b1;
      end else begin
         irq_empty <= fifo_empty && (state == IDLE);
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (!fifo_empty) begin
                  shift <= fifo_dout;
                  baud  <= '0;
                  tx    <= 1'b0;
                  state <= START;
               end
            end
            START: begin
               if (baud == BAUD_LAST) begin
                  baud  <= '0;
                  idx   <= '0;
                  tx    <= shift[0];
                  state <= DATA;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            DATA: begin
               if (baud == BAUD_LAST) begin
                  baud  <= '0;
                  shift <= shift >> 1;
                  idx   <= idx + 1'b1;
                  if (idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     tx <= shift[1];
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            STOP: begin
               if (baud == BAUD_LAST) begin
                  baud  <= '0;
                  tx    <= 1'b1;
                  state <= IDLE;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_port.sv
// tb/tb_uart_tx_port.sv - bench for uart_tx_port: frame-timeline model plus directed literal checks
module tb_uart_tx_port;

   localparam int          C    = 4;
   localparam int          D    = 8;
   localparam logic [31:0] BASE = 32'h4700;
   localparam logic [31:0] STAT = 32'h4704;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic        we    = 1'b0;
   logic [31:0] adr   = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        sel;
   logic        tx;
   logic        irq_empty;

   always #5 clk = ~clk;

   uart_tx_port #(.DEPTH(D), .CLKS_PER_BIT(C), .BASE(BASE)) dut (
      .clk       (clk),
      .reset     (reset),
      .adr       (adr),
      .we        (we),
      .wdata     (wdata),
      .rdata     (rdata),
      .sel       (sel),
      .tx        (tx),
      .irq_empty (irq_empty)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: byte queue plus one frame timer; the line value is picked from {stop, byte, start} by t/C.
   logic [7:0] m_q[$];
   bit         m_active = 1'b0;
   int         m_t      = 0;
   logic [7:0] m_byte   = 8'h00;
   bit         m_ovf    = 1'b0;
   bit         m_irq    = 1'b1;

   function automatic logic m_tx();
      int k;
      if (!m_active) return 1'b1;
      k = m_t / C;
      if (k == 0) return 1'b0;
      if (k <= 8) return m_byte[k-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] m_status(input logic [31:0] a);
      int n;
      logic [3:0] c4;
      if (a != BASE && a != STAT) return 32'h0;
      n  = m_q.size();
      c4 = (n > 15) ? 4'hF : 4'(n);
      return {24'h0, c4, m_ovf, m_active, (n == 0), (n == D)};
   endfunction

   logic [7:0] rx_q[$];
   bit         rx_busy = 1'b0;
   int         rx_t    = 0;
   logic [7:0] rx_sh   = 8'h00;

   always @(posedge clk) begin : model
      bit pop;
      logic [7:0] popped;
      pop    = 1'b0;
      popped = 8'h00;
      if (!reset) begin
         m_q.delete();
         m_active = 1'b0;
         m_t      = 0;
         m_ovf    = 1'b0;
         m_irq    = 1'b1;
      end else begin
         m_irq = (m_q.size() == 0) && !m_active;
         pop   = !m_active && (m_q.size() > 0);
         if (pop) popped = m_q.pop_front();
         if (we && adr == BASE) begin
            if (m_q.size() < D) m_q.push_back(wdata[7:0]);
            else m_ovf = 1'b1;
         end
         if (we && adr == STAT && wdata[3]) m_ovf = 1'b0;
         if (m_active) begin
            m_t++;
            if (m_t == 10*C) m_active = 1'b0;
         end else if (pop) begin
            m_active = 1'b1;
            m_t      = 0;
            m_byte   = popped;
         end
      end
      #1;
      chk("tx", tx, m_tx());
      chk("irq_empty", irq_empty, m_irq);
      chk("sel", sel, (adr == BASE || adr == STAT));
      chk("rdata", rdata, m_status(adr));
      // Independent line receiver, sampling mid-bit.
      if (!reset) begin
         rx_busy = 1'b0;
      end else if (!rx_busy) begin
         if (tx === 1'b0) begin
            rx_busy = 1'b1;
            rx_t    = 0;
         end
      end else begin
         rx_t++;
         if (rx_t > C && rx_t < 9*C && (rx_t % C) == C/2) rx_sh = {tx, rx_sh[7:1]};
         if (rx_t == 9*C + C/2) begin
            chk("stop_bit", tx, 1'b1);
            rx_q.push_back(rx_sh);
            rx_busy = 1'b0;
         end
      end
   end

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      adr   = a;
      wdata = d;
      we    = 1'b1;
   endtask

   task automatic idle_read(input logic [31:0] a);
      @(negedge clk);
      we    = 1'b0;
      adr   = a;
      wdata = '0;
      #1;
   endtask

   initial begin
      logic [9:0] pat;
      logic [7:0] exp_rx[$];
      int         guard;
      int         rx_n;

      // Reset held for three clocks.
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      idle_read(STAT);
      chk("reset_status", rdata, 32'h0000_0002);
      chk("reset_tx", tx, 1'b1);
      chk("reset_irq", irq_empty, 1'b1);

      // Single byte 55h.
      pat = 10'b1010101010;
      store(BASE, 32'hFFFF_FF55);
      idle_read(STAT);
      chk("latency_edge1_tx", tx, 1'b1);
      for (int i = 0; i < 10*C; i++) begin
         @(negedge clk);
         chk($sformatf("frame55_cyc%0d", i), tx, pat[i/C]);
      end
      @(negedge clk);
      chk("frame_end_irq_low", irq_empty, 1'b0);
      chk("frame_end_tx", tx, 1'b1);
      @(negedge clk);
      chk("frame_end_irq_high", irq_empty, 1'b1);

      // Nine back-to-back stores: the first leaves at once, so all nine fit.
      for (int k = 1; k <= 9; k++) store(BASE, {24'hABCDEF, 8'(k)});
      idle_read(STAT);
      chk("after9_status", rdata, 32'h0000_0085);
      store(BASE, 32'h0000_000A);
      idle_read(STAT);
      chk("overflow_status", rdata, 32'h0000_008D);
      store(STAT, 32'h0000_0008);
      idle_read(STAT);
      chk("ovf_clear_status", rdata, 32'h0000_0085);
      chk("ovf_clear_sel", sel, 1'b1);

      // Store timed onto the edge where the serializer pops a full FIFO.
      guard = 0;
      while (!(!m_active && m_q.size() == D) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk("wait_pop_edge_timeout", (guard < 200), 1'b1);
      adr   = BASE;
      wdata = 32'h0000_000B;
      we    = 1'b1;
      idle_read(STAT);
      chk("push_pop_full_status", rdata, 32'h0000_0085);

      // Drain and confirm the line order.
      guard = 0;
      while (!(m_q.size() == 0 && !m_active) && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      chk("drain_timeout", (guard < 2000), 1'b1);
      repeat (4) @(negedge clk);
      exp_rx = {8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0B};
      chk("rx_count", rx_q.size(), exp_rx.size());
      for (int i = 0; i < exp_rx.size(); i++) begin
         if (i < rx_q.size()) chk($sformatf("rx_byte%0d", i), rx_q[i], exp_rx[i]);
      end

      // Writes elsewhere are ignored.
      store(32'h0000_4708, 32'h0000_0077);
      store(32'h0000_4700 - 32'd4, 32'h0000_0008);
      idle_read(32'h0000_4708);
      chk("other_sel", sel, 1'b0);
      chk("other_rdata", rdata, 32'h0);
      idle_read(STAT);
      chk("other_status", rdata, 32'h0000_0002);

      // Reset during data bit 3 of A5h with 3Ch still queued.
      rx_n = rx_q.size();
      store(BASE, 32'h0000_00A5);
      store(BASE, 32'h0000_003C);
      idle_read(STAT);
      repeat (17) @(negedge clk);
      chk("a5_bit3_tx", tx, 1'b0);
      reset = 1'b0;
      #1;
      chk("async_reset_tx", tx, 1'b1);
      chk("async_reset_irq", irq_empty, 1'b1);
      chk("async_reset_status", rdata, 32'h0000_0002);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      idle_read(STAT);
      chk("post_reset_status", rdata, 32'h0000_0002);
      repeat (60) @(negedge clk);
      chk("no_frames_after_reset", rx_q.size(), rx_n);
      chk("idle_line", tx, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
